// File: rtl/f4_puzzle_gpu.sv
// N x N row/column-rotation puzzle engine between the VGA mapper and the image ROM.
// Owns cursor, rotation offsets, LFSR shuffle, cursor flash and a 2-stage pixel pipeline.
module f4_puzzle_gpu #(
  parameter int unsigned GRID_BITS     = 4,
  parameter int unsigned PIX_W         = 3,
  parameter int unsigned WIN_X0        = 231,
  parameter int unsigned WIN_X1        = 711,
  parameter int unsigned WIN_Y0        = 36,
  parameter int unsigned WIN_Y1        = 516,
  parameter int unsigned FLASH_BITS    = 25,
  parameter int unsigned SHUFFLE_MOVES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     sysclk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  input  logic [3:0]               instruction,
  input  logic [21:0]              display_addr,
  input  logic [GRID_BITS-1:0]     mapper_cell_x,
  input  logic [GRID_BITS-1:0]     mapper_cell_y,
  input  logic [PIX_W-1:0]         pixel_data,
  output logic [21:0]              mapper_display_addr,
  output logic [2*GRID_BITS-1:0]   pixel_addr,
  output logic [PIX_W-1:0]         display_data,
  output logic [1:0]               mode,
  output logic                     solved
);

  localparam int unsigned GB    = GRID_BITS;
  localparam int unsigned N     = 2**GRID_BITS;
  localparam int unsigned CNT_W = 17;
  localparam int unsigned CRD_W = 10;

  typedef enum logic [1:0] {
    NAV     = 2'd0,
    SHUFFLE = 2'd1,
    PLAY    = 2'd2
  } mode_e;

  mode_e               r_mode;
  mode_e               w_mode_nxt;
  logic [GB-1:0]       r_cur_x;
  logic [GB-1:0]       r_cur_y;
  logic [GB-1:0]       r_row_off [N];
  logic [GB-1:0]       r_col_off [N];
  logic [15:0]         r_lfsr;
  logic [CNT_W-1:0]    r_shuf_cnt;
  logic [FLASH_BITS-1:0] r_flash;
  logic                r_phase;
  logic                r_solved;
  logic                r_s1_vld;
  logic                r_s1_in_win;
  logic                r_s1_hit;
  logic [2*GB-1:0]     r_pixel_addr;
  logic [PIX_W-1:0]    r_display_data;

  logic                w_move;
  logic                w_cnt_inc;
  logic                w_all_zero;
  logic                w_row_en;
  logic                w_col_en;
  logic [GB-1:0]       w_row_idx;
  logic [GB-1:0]       w_col_idx;
  logic [GB-1:0]       w_step;
  logic [GB-1:0]       w_lfsr_idx;
  logic                w_lfsr_fb;
  logic [CRD_W-1:0]    w_x;
  logic [CRD_W-1:0]    w_y;
  logic                w_in_win;
  logic [GB-1:0]       w_src_x;
  logic [GB-1:0]       w_src_y;

  assign mapper_display_addr = display_addr;
  assign pixel_addr          = r_pixel_addr;
  assign display_data        = r_display_data;
  assign mode                = r_mode;
  assign solved              = r_solved;

  assign w_lfsr_idx = r_lfsr[GB+1:2];
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Mode sequencing; the extra shuffle move only fires if the last real move left the grid solved.
  always_comb begin
    w_mode_nxt = r_mode;
    w_move     = 1'b0;
    w_cnt_inc  = 1'b0;
    case (r_mode)
      NAV: begin
        if (instr_valid && instruction == 4'd5) w_mode_nxt = SHUFFLE;
      end
      SHUFFLE: begin
        if (r_shuf_cnt < CNT_W'(SHUFFLE_MOVES)) begin
          w_move    = 1'b1;
          w_cnt_inc = 1'b1;
        end else begin
          w_move     = w_all_zero;
          w_mode_nxt = PLAY;
        end
      end
      PLAY: begin
        if (instr_valid && instruction == 4'd5) w_mode_nxt = NAV;
      end
      default: w_mode_nxt = NAV;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) r_mode <= NAV;
    else        r_mode <= w_mode_nxt;
  end

  // Offset update select: shuffle move takes priority; player rotations only in PLAY.
  always_comb begin
    w_row_en  = 1'b0;
    w_col_en  = 1'b0;
    w_row_idx = r_cur_y;
    w_col_idx = r_cur_x;
    w_step    = GB'(1);
    if (w_move) begin
      w_step = r_lfsr[1] ? GB'(1) : '1;
      if (r_lfsr[0]) begin
        w_row_en  = 1'b1;
        w_row_idx = w_lfsr_idx;
      end else begin
        w_col_en  = 1'b1;
        w_col_idx = w_lfsr_idx;
      end
    end else if (instr_valid && r_mode == PLAY) begin
      case (instruction)
        4'd6: w_col_en = 1'b1;
        4'd7: begin w_col_en = 1'b1; w_step = '1; end
        4'd8: w_row_en = 1'b1;
        4'd9: begin w_row_en = 1'b1; w_step = '1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_all_zero = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (r_row_off[i] != '0 || r_col_off[i] != '0) w_all_zero = 1'b0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_row_off[i] <= '0;
        r_col_off[i] <= '0;
      end
    end else begin
      if (w_row_en) r_row_off[w_row_idx] <= r_row_off[w_row_idx] + w_step;
      if (w_col_en) r_col_off[w_col_idx] <= r_col_off[w_col_idx] + w_step;
    end
  end

  // Cursor moves wrap naturally at the grid edge.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else if (instr_valid && r_mode != SHUFFLE) begin
      case (instruction)
        4'd1:    r_cur_y <= r_cur_y - GB'(1);
        4'd2:    r_cur_x <= r_cur_x + GB'(1);
        4'd3:    r_cur_x <= r_cur_x - GB'(1);
        4'd4:    r_cur_y <= r_cur_y + GB'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr     <= LFSR_SEED;
      r_shuf_cnt <= '0;
      r_solved   <= 1'b0;
      r_flash    <= '0;
      r_phase    <= 1'b0;
    end else begin
      if (w_move) r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      if (r_mode != SHUFFLE) r_shuf_cnt <= '0;
      else if (w_cnt_inc)    r_shuf_cnt <= r_shuf_cnt + CNT_W'(1);
      r_solved <= (r_mode == PLAY) && w_all_zero;
      r_flash  <= r_flash + FLASH_BITS'(1);
      if (&r_flash) r_phase <= ~r_phase;
    end
  end

  assign w_x      = display_addr[19:10];
  assign w_y      = display_addr[9:0];
  assign w_in_win = (w_x >= CRD_W'(WIN_X0)) && (w_x <= CRD_W'(WIN_X1)) &&
                    (w_y >= CRD_W'(WIN_Y0)) && (w_y <= CRD_W'(WIN_Y1));
  assign w_src_x  = mapper_cell_x + r_row_off[mapper_cell_y];
  assign w_src_y  = mapper_cell_y + r_col_off[w_src_x];

  // S1 address/window/hit stage, S2 colour stage.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld       <= 1'b0;
      r_s1_in_win    <= 1'b0;
      r_s1_hit       <= 1'b0;
      r_pixel_addr   <= '0;
      r_display_data <= '0;
    end else begin
      r_s1_vld     <= 1'b1;
      r_s1_in_win  <= w_in_win;
      r_s1_hit     <= (mapper_cell_x == r_cur_x) && (mapper_cell_y == r_cur_y) &&
                      (r_mode != SHUFFLE);
      r_pixel_addr <= {w_src_y, w_src_x};
      if (!r_s1_vld || !r_s1_in_win)  r_display_data <= '0;
      else if (r_s1_hit && r_phase)   r_display_data <= ~pixel_data;
      else                            r_display_data <= pixel_data;
    end
  end

endmodule
